// File: rtl/trig_step_ctrl_if.sv
// Control/status bundle between the anti-jitter front end, the trigger bank
// and the clock-step scheduler.
interface trig_step_ctrl_if #(
    parameter int DIV_W  = 26,
    parameter int HIST_D = 8
);
    logic [1:0]          mode;
    logic                step_pulse;
    logic [DIV_W-1:0]    period;
    logic [7:0]          burst_len;
    logic [2:0]          q_in;
    logic                CK;
    logic                ck_rise;
    logic                busy;
    logic                burst_done;
    logic [3*HIST_D-1:0] q_hist;
    logic [15:0]         pulse_cnt;

    // Front end drives the controls and observes the scheduler.
    modport master (
        output mode, step_pulse, period, burst_len, q_in,
        input  CK, ck_rise, busy, burst_done, q_hist, pulse_cnt
    );

    // Scheduler side.
    modport slave (
        input  mode, step_pulse, period, burst_len, q_in,
        output CK, ck_rise, busy, burst_done, q_hist, pulse_cnt
    );
endinterface

// File: rtl/trig_step_ctrl.sv
// Trigger clock step scheduler: generates CK in stop / free-run /
// single-step / burst mode with a programmable half-period, and records the
// trigger Q outputs after every pulse into a shift history.
module trig_step_ctrl #(
    parameter int DIV_W  = 26,
    parameter int HIST_D = 8
) (
    input  logic                 clk,
    input  logic                 RSTN,
    trig_step_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_FREE  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // A half-period of zero would never terminate a phase; run it as one.
    function automatic logic [DIV_W-1:0] clamp_period(input logic [DIV_W-1:0] p);
        return (p == '0) ? DIV_W'(1) : p;
    endfunction

    state_t              state_r, state_n;
    logic [DIV_W-1:0]    cnt_r, cnt_n;     // cycles left in the current phase, minus one
    logic [DIV_W-1:0]    per_r, per_n;     // latched half-period
    logic [7:0]          rem_r, rem_n;     // pulses left in the burst, including current
    logic [1:0]          run_r, run_n;     // mode that launched the current run
    logic [3*HIST_D-1:0] hist_r, hist_n;
    logic [15:0]         pcnt_r, pcnt_n;
    logic                ck_r, ck_rise_r, busy_r, burst_done_r;
    logic                start_s, rise_s, done_s;

    // Next-state, phase counting, latching and history shift.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        per_n   = per_r;
        rem_n   = rem_r;
        run_n   = run_r;
        hist_n  = hist_r;
        pcnt_n  = pcnt_r;
        start_s = 1'b0;
        rise_s  = 1'b0;
        done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.mode == MODE_FREE) begin
                    start_s = 1'b1;
                end else if (bus.mode == MODE_STEP && bus.step_pulse) begin
                    start_s = 1'b1;
                end else if (bus.mode == MODE_BURST && bus.step_pulse) begin
                    if (bus.burst_len != 8'd0) begin
                        start_s = 1'b1;
                        rem_n   = bus.burst_len;
                    end else begin
                        // Empty burst: report completion without any pulse.
                        done_s = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            HIGH: begin
                if (cnt_r == '0) begin
                    // Last high cycle: the triggers have settled on this edge.
                    hist_n  = {hist_r[3*HIST_D-4:0], bus.q_in};
                    state_n = LOW;
                    cnt_n   = per_r - DIV_W'(1);
                end else begin
                    cnt_n = cnt_r - DIV_W'(1);
                end
            end
            LOW: begin
                if (cnt_r != '0) begin
                    cnt_n = cnt_r - DIV_W'(1);
                end else if (run_r == MODE_FREE && bus.mode == MODE_FREE) begin
                    // Back-to-back pulses with a fresh period, no gap cycle.
                    start_s = 1'b1;
                end else if (run_r == MODE_BURST && bus.mode == MODE_BURST && rem_r > 8'd1) begin
                    rem_n   = rem_r - 8'd1;
                    state_n = HIGH;
                    cnt_n   = per_r - DIV_W'(1);
                end else if (run_r == MODE_BURST && bus.mode == MODE_BURST && rem_r == 8'd1) begin
                    state_n = FIN;
                    done_s  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (start_s) begin
            state_n = HIGH;
            run_n   = bus.mode;
            per_n   = clamp_period(bus.period);
            cnt_n   = clamp_period(bus.period) - DIV_W'(1);
        end else begin
            run_n = run_n;
        end

        if (state_n == HIGH && state_r != HIGH) begin
            rise_s = 1'b1;
        end else begin
            rise_s = 1'b0;
        end

        if (rise_s && pcnt_r != 16'hFFFF) begin
            pcnt_n = pcnt_r + 16'd1;
        end else begin
            pcnt_n = pcnt_r;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            per_r        <= '0;
            rem_r        <= 8'd0;
            run_r        <= 2'b00;
            hist_r       <= '0;
            pcnt_r       <= 16'd0;
            ck_r         <= 1'b0;
            ck_rise_r    <= 1'b0;
            busy_r       <= 1'b0;
            burst_done_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            per_r        <= per_n;
            rem_r        <= rem_n;
            run_r        <= run_n;
            hist_r       <= hist_n;
            pcnt_r       <= pcnt_n;
            ck_r         <= (state_n == HIGH);
            ck_rise_r    <= rise_s;
            busy_r       <= (state_n != IDLE);
            burst_done_r <= done_s;
        end
    end

    assign bus.CK         = ck_r;
    assign bus.ck_rise    = ck_rise_r;
    assign bus.busy       = busy_r;
    assign bus.burst_done = burst_done_r;
    assign bus.q_hist     = hist_r;
    assign bus.pulse_cnt  = pcnt_r;
endmodule

// File: doc/trig_step_ctrl.md
Name: trig_step_ctrl

Overview:
Clock-step scheduler for the flip-flop experiment datapath (RS, D and master-slave D triggers). It generates the trigger clock CK from the 100 MHz system clock in stop, free-run, single-step or burst mode, with a programmable half-period. After every CK pulse it samples the three trigger Q outputs into a shift history for LED display. It sits between the anti-jitter block (mode switches, step button pulse) and the trigger bank, and replaces the plain divider/pulse mux.

Parameters:
DIV_W, 26, width of half-period counter and of period input
HIST_D, 8, history depth in samples (each sample 3 bits)

Ports:
clk  in  1  system clock, 100 MHz
RSTN  in  1  synchronous active-low reset
mode  in  2  00 stop, 01 free-run, 10 single-step, 11 burst
step_pulse  in  1  one-clk debounced button pulse; starts a step or a burst
period  in  DIV_W  CK half-period in clk cycles; 0 treated as 1
burst_len  in  8  number of CK pulses per burst; 0 means no pulses
q_in  in  3  {RS_Q, D_Q, MBD_Q} from the trigger bank
CK  out  1  registered trigger clock
ck_rise  out  1  one-clk strobe on the first clk cycle CK is high
busy  out  1  1 whenever state != IDLE
burst_done  out  1  one-clk strobe when a burst completes normally
q_hist  out  3*HIST_D  sample history; newest in [2:0]
pulse_cnt  out  16  CK rising edges since reset, saturates at 16'hFFFF

Behaviour:
- Reset (RSTN=0 at a clk edge): state IDLE, CK=0, ck_rise=0, busy=0, burst_done=0, q_hist=0, pulse_cnt=0, internal counters=0. Reset mid-pulse drops CK on the next edge with no completion.
- States: IDLE, HIGH, LOW, FIN.
- IDLE -> HIGH: on mode=01 (level), on mode=10 with step_pulse=1, or on mode=11 with step_pulse=1 and burst_len!=0. If step_pulse occurs at cycle t, CK=1 and ck_rise=1 at t+1.
- On IDLE->HIGH: latch P=max(period,1). In burst mode also latch remaining=burst_len.
- HIGH: CK=1 for exactly P cycles. On the last HIGH cycle, shift q_in into q_hist (q_hist <= {q_hist[3*HIST_D-4:0], q_in}), then go to LOW.
- LOW: CK=0 for exactly P cycles. Then:
  - free-run with mode still 01: go directly to HIGH. The period is re-latched and there is no gap cycle.
  - burst with remaining>1 and mode still 11: decrement remaining, go to HIGH.
  - burst with remaining==1: go to FIN.
  - otherwise: go to IDLE.
- FIN: burst_done=1 for one cycle, then IDLE.
- A pulse always completes. A mode or period change never truncates HIGH or LOW, so CK never glitches. A mode change takes effect only at the LOW-phase exit decision. Leaving mode 11 mid-burst ends after the current pulse, with no burst_done.
- step_pulse is ignored when state != IDLE. It is not queued.
- mode=11 with burst_len=0 and step_pulse: no CK pulse, stays IDLE, burst_done=1 for one cycle.
- pulse_cnt increments on each ck_rise and saturates at 16'hFFFF.
- period and burst_len are sampled only at latch points. Changes mid-pulse are invisible until the next latch.
- Full CK period = 2P clk cycles. Single-step from IDLE: busy is high for 2P cycles starting at t+1.

Test Plan:
- Reset then single-step, period=3, mode=10, step_pulse at t=10 -> CK=1 for cycles 11-13 and 0 for 14-16, ck_rise only at 11, IDLE at 17, pulse_cnt=1.
- Free-run, period=2 -> CK pattern 1100 repeating, no gap. After 5 rises pulse_cnt=5. Switching mode to 00 during HIGH -> pulse finishes (2 high + 2 low), then IDLE.
- Burst, burst_len=4, period=1 -> exactly 4 CK pulses (1010 1010), burst_done one cycle after the last LOW. Extra step_pulse mid-burst is ignored.
- History capture: q_in driven 3'b101 then 3'b010 over two steps -> q_hist[5:0]=6'b101010. Nine samples -> the oldest sample is dropped.
- Edge cases: period=0 -> behaves as 1. Burst with burst_len=0 -> no CK, burst_done pulses. Changing period mid-HIGH does not alter the current phase.
- Reset mid-burst (RSTN=0 during HIGH) -> next edge CK=0, q_hist=0, pulse_cnt=0, busy=0, no burst_done.
